// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes three slot sensors, debounces a single coin,
// rejects jams and queues accepted coins in a small FIFO paced by a gap counter.
module coin_acceptor #(
   parameter int DEBOUNCE = 4,
   parameter int GAP      = 1,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sense_q,
   input  logic       sense_h,
   input  logic       sense_d,
   input  logic       inhibit,
   output logic [2:0] coin,
   output logic       reject_coin,
   output logic       return_coin,
   output logic [2:0] fifo_count,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, QUALIFY, WAIT_RELEASE} state_t;

   state_t     state, next_state;
   logic [3:0] cnt, next_cnt;
   logic [2:0] code, next_code;
   logic       jam, accept;

   logic [2:0] sync1, sync2;
   logic       s_q, s_h, s_d;
   logic [2:0] s_vec;

   logic [2:0] mem [DEPTH];
   logic [1:0] wptr, rptr;
   logic [2:0] gap_cnt;
   logic       pop, push;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sense_d, sense_h, sense_q};
         sync2 <= sync1;
      end
   end

   assign s_q   = sync2[0];
   assign s_h   = sync2[1];
   assign s_d   = sync2[2];
   // Bit positions line up with the coin codes, so the vector is the code.
   assign s_vec = {s_d, s_h, s_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         code  <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         code  <= next_code;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_code  = code;
      jam        = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if ($onehot(s_vec)) begin
               next_state = QUALIFY;
               next_cnt   = 4'd1;
               next_code  = s_vec;
            end else if (s_vec != 3'b000) begin
               next_state = WAIT_RELEASE;
               jam        = 1'b1;
            end
         end
         QUALIFY: begin
            // A second sensor wins over a debounce that completes this cycle.
            if ((s_vec & ~code) != 3'b000) begin
               jam        = 1'b1;
               next_state = WAIT_RELEASE;
               next_cnt   = '0;
            end else if ((s_vec & code) == 3'b000) begin
               next_state = IDLE;
               next_cnt   = '0;
            end else if (cnt + 4'd1 == 4'(DEBOUNCE)) begin
               accept     = 1'b1;
               next_state = WAIT_RELEASE;
               next_cnt   = '0;
            end else begin
               next_cnt   = cnt + 4'd1;
            end
         end
         WAIT_RELEASE: begin
            if (s_vec == 3'b000) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign pop  = (fifo_count != 3'd0) && !inhibit && (gap_cnt == 3'd0);
   assign push = accept && ((fifo_count < 3'(DEPTH)) || pop);
   assign busy = (state != IDLE) || (fifo_count != 3'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr        <= '0;
         rptr        <= '0;
         fifo_count  <= '0;
         gap_cnt     <= '0;
         coin        <= '0;
         reject_coin <= 1'b0;
         return_coin <= 1'b0;
      end else begin
         if (push) begin
            mem[wptr] <= code;
            wptr      <= wptr + 2'd1;
         end
         if (pop) rptr <= rptr + 2'd1;
         if (push && !pop)      fifo_count <= fifo_count + 3'd1;
         else if (pop && !push) fifo_count <= fifo_count - 3'd1;
         coin <= pop ? mem[rptr] : 3'b000;
         // Loading GAP at the pop means GAP idle cycles follow the pulse.
         if (pop)                  gap_cnt <= 3'(GAP);
         else if (gap_cnt != 3'd0) gap_cnt <= gap_cnt - 3'd1;
         reject_coin <= jam;
         return_coin <= accept && !push;
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor (DEBOUNCE=4, GAP=3).
module tb_coin_acceptor;

   localparam int DEBOUNCE = 4;
   localparam int GAP      = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sense_q = 1'b0, sense_h = 1'b0, sense_d = 1'b0;
   logic       inhibit = 1'b0;
   logic [2:0] coin;
   logic       reject_coin, return_coin, busy;
   logic [2:0] fifo_count;

   int checks = 0, errors = 0, cycle = 0, rejects = 0, returns = 0;
   logic [2:0] coin_log [$];
   int         coin_cyc [$];

   always #5 clk = ~clk;

   coin_acceptor #(.DEBOUNCE(DEBOUNCE), .GAP(GAP), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .sense_q(sense_q), .sense_h(sense_h), .sense_d(sense_d),
      .inhibit(inhibit), .coin(coin), .reject_coin(reject_coin),
      .return_coin(return_coin), .fifo_count(fifo_count), .busy(busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] s);
      {sense_d, sense_h, sense_q} = s;
   endtask

   // Advance n edges, sampling 1 time unit after each edge and logging pulses.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cycle++;
         if (coin !== 3'b000) begin
            coin_log.push_back(coin);
            coin_cyc.push_back(cycle);
         end
         if (reject_coin === 1'b1) rejects++;
         if (return_coin === 1'b1) returns++;
      end
   endtask

   task automatic clearLog();
      coin_log.delete();
      coin_cyc.delete();
      rejects = 0;
      returns = 0;
   endtask

   task automatic insertCoin(input logic [2:0] s);
      applyStimulus(s);
      tick(6);
      applyStimulus(3'b000);
      tick(4);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tick(3);
      checkOutput("rst_coin",   32'(coin), 32'd0);
      checkOutput("rst_reject", 32'(reject_coin), 32'd0);
      checkOutput("rst_return", 32'(return_coin), 32'd0);
      checkOutput("rst_count",  32'(fifo_count), 32'd0);
      checkOutput("rst_busy",   32'(busy), 32'd0);
      reset = 1'b1;
      tick(2);

      // Fifty held 8 cycles: push at edge 6, pulse after edge 7.
      clearLog();
      applyStimulus(3'b010);
      tick(6);
      checkOutput("lat_pre",   32'(coin), 32'd0);
      checkOutput("lat_push",  32'(fifo_count), 32'd1);
      tick(1);
      checkOutput("lat_coin",  32'(coin), 32'b010);
      tick(1);
      checkOutput("lat_clear", 32'(coin), 32'd0);
      applyStimulus(3'b000);
      tick(10);
      checkOutput("lat_npulse", 32'(coin_log.size()), 32'd1);
      checkOutput("lat_reject", 32'(rejects), 32'd0);
      checkOutput("lat_return", 32'(returns), 32'd0);
      checkOutput("lat_idle",   32'(busy), 32'd0);

      // Two-cycle quarter glitch is discarded.
      clearLog();
      applyStimulus(3'b001);
      tick(2);
      applyStimulus(3'b000);
      tick(1);
      checkOutput("glitch_qual",   32'(busy), 32'd1);
      tick(8);
      checkOutput("glitch_npulse", 32'(coin_log.size()), 32'd0);
      checkOutput("glitch_count",  32'(fifo_count), 32'd0);
      checkOutput("glitch_idle",   32'(busy), 32'd0);

      // Quarter and dollar together: one reject, held until both release.
      clearLog();
      applyStimulus(3'b101);
      tick(6);
      checkOutput("jam_reject", 32'(rejects), 32'd1);
      checkOutput("jam_busy",   32'(busy), 32'd1);
      applyStimulus(3'b100);
      tick(6);
      checkOutput("jam_hold",   32'(busy), 32'd1);
      applyStimulus(3'b000);
      tick(6);
      checkOutput("jam_idle",    32'(busy), 32'd0);
      checkOutput("jam_reject1", 32'(rejects), 32'd1);
      checkOutput("jam_npulse",  32'(coin_log.size()), 32'd0);

      // Fifty arrives in the very cycle the quarter would be accepted.
      clearLog();
      applyStimulus(3'b001);
      tick(3);
      applyStimulus(3'b011);
      tick(5);
      applyStimulus(3'b000);
      tick(6);
      checkOutput("prio_reject", 32'(rejects), 32'd1);
      checkOutput("prio_npulse", 32'(coin_log.size()), 32'd0);
      checkOutput("prio_count",  32'(fifo_count), 32'd0);

      // Five dollars under inhibit: four queued, fifth returned.
      clearLog();
      inhibit = 1'b1;
      for (int i = 0; i < 4; i++) insertCoin(3'b100);
      checkOutput("fill_count4", 32'(fifo_count), 32'd4);
      checkOutput("fill_ret0",   32'(returns), 32'd0);
      insertCoin(3'b100);
      checkOutput("fill_full",   32'(fifo_count), 32'd4);
      checkOutput("fill_ret1",   32'(returns), 32'd1);
      checkOutput("fill_held",   32'(coin_log.size()), 32'd0);
      inhibit = 1'b0;
      tick(30);
      checkOutput("drain_npulse", 32'(coin_log.size()), 32'd4);
      if (coin_log.size() == 4) begin
         for (int i = 0; i < 4; i++) checkOutput("drain_code", 32'(coin_log[i]), 32'b100);
         for (int i = 1; i < 4; i++)
            checkOutput("drain_gap", 32'(coin_cyc[i] - coin_cyc[i-1] > GAP), 32'd1);
      end
      checkOutput("drain_count", 32'(fifo_count), 32'd0);

      // Quarter then fifty with GAP=3: pulse, three zeros, pulse.
      clearLog();
      inhibit = 1'b1;
      insertCoin(3'b001);
      insertCoin(3'b010);
      checkOutput("order_count", 32'(fifo_count), 32'd2);
      inhibit = 1'b0;
      tick(12);
      checkOutput("order_npulse", 32'(coin_log.size()), 32'd2);
      if (coin_log.size() == 2) begin
         checkOutput("order_first",  32'(coin_log[0]), 32'b001);
         checkOutput("order_second", 32'(coin_log[1]), 32'b010);
         checkOutput("order_spacing", 32'(coin_cyc[1] - coin_cyc[0]), 32'(GAP + 1));
      end

      // Reset with two queued coins and a dollar qualifying.
      clearLog();
      inhibit = 1'b1;
      insertCoin(3'b001);
      insertCoin(3'b001);
      applyStimulus(3'b100);
      tick(4);
      checkOutput("mid_count", 32'(fifo_count), 32'd2);
      checkOutput("mid_busy",  32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("arst_coin",   32'(coin), 32'd0);
      checkOutput("arst_reject", 32'(reject_coin), 32'd0);
      checkOutput("arst_return", 32'(return_coin), 32'd0);
      checkOutput("arst_count",  32'(fifo_count), 32'd0);
      checkOutput("arst_busy",   32'(busy), 32'd0);
      applyStimulus(3'b000);
      inhibit = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(20);
      checkOutput("post_npulse", 32'(coin_log.size()), 32'd0);
      checkOutput("post_count",  32'(fifo_count), 32'd0);
      checkOutput("post_busy",   32'(busy), 32'd0);

      // Sensor still high across reset release counts as a fresh coin.
      clearLog();
      reset = 1'b0;
      applyStimulus(3'b010);
      tick(2);
      reset = 1'b1;
      tick(12);
      applyStimulus(3'b000);
      tick(10);
      checkOutput("rel_npulse", 32'(coin_log.size()), 32'd1);
      if (coin_log.size() == 1) checkOutput("rel_code", 32'(coin_log[0]), 32'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
